// File: rtl/stage_mm_pkg.sv
// Shared widths and FSM encodings for the memory stage; these macros stand in for defines.vh.
// Each can be overridden on the command line; MM_TIMEOUT_EN is consumed by stage_mm.sv.
`ifndef DATA_W
`define DATA_W 32
`endif
`ifndef REG_ADDR_W
`define REG_ADDR_W 5
`endif
`ifndef MM_ST_IDLE
`define MM_ST_IDLE 1'b0
`endif
`ifndef MM_ST_WAIT
`define MM_ST_WAIT 1'b1
`endif

package stage_mm_pkg;
  localparam int MM_DATA_W     = `DATA_W;
  localparam int MM_REG_ADDR_W = `REG_ADDR_W;

  typedef enum logic {
    MM_IDLE = `MM_ST_IDLE,
    MM_WAIT = `MM_ST_WAIT
  } mm_state_e;
endpackage

// File: rtl/stage_mm.sv
// Memory-access pipeline stage: issues one data-memory request per load/store and stalls upstream
// until dmem_ack. Define MM_TIMEOUT_EN to abandon a request after ACK_TIMEOUT silent WAIT cycles.
module stage_mm
  import stage_mm_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     in_flush,
  input  logic                     in_reg_wr,
  input  logic [MM_REG_ADDR_W-1:0] in_reg_addr_rd,
  input  logic [MM_DATA_W-1:0]     in_alu_res,
  input  logic                     in_mem_rd,
  input  logic                     in_mem_wr,
  input  logic [MM_DATA_W-1:0]     in_mem_wdata,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [MM_DATA_W-1:0]     dmem_addr,
  output logic [MM_DATA_W-1:0]     dmem_wdata,
  input  logic                     dmem_ack,
  input  logic [MM_DATA_W-1:0]     dmem_rdata,
  output logic                     stall_req,
  output logic                     out_reg_wr,
  output logic [MM_REG_ADDR_W-1:0] out_reg_addr_rd,
  output logic [MM_DATA_W-1:0]     out_reg_data,
  output logic                     out_flush,
  output logic                     ffw_MM_reg_wr,
  output logic [MM_REG_ADDR_W-1:0] ffw_MM_reg_addr_rd,
  output logic [MM_DATA_W-1:0]     ffw_MM_reg_data_rd,
  output logic                     err,
  output mm_state_e                state_dbg
);

  // Memory handshake: dmem_req rises with address/data/we and all four stay stable until the
  // single-cycle dmem_ack; the ack completes the transfer only while en=1 and only in WAIT.
  mm_state_e state, state_nxt;
  logic      mop;
  logic      ack_take;
  logic      timeout_hit;

  assign mop      = !in_flush && (in_mem_rd || in_mem_wr);
  assign ack_take = en && dmem_ack;

`ifdef MM_TIMEOUT_EN
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;

  assign timeout_hit = en && (state == MM_WAIT) && !dmem_ack &&
                       (wait_cnt == CNT_W'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else if (en) begin
      err <= timeout_hit;
      if (state == MM_WAIT && !dmem_ack && !timeout_hit) wait_cnt <= wait_cnt + 1'b1;
      else                                               wait_cnt <= '0;
    end
  end
`else
  logic unused_ack_timeout;
  assign unused_ack_timeout = ACK_TIMEOUT[0];
  assign timeout_hit        = 1'b0;
  assign err                = 1'b0;
`endif

  assign stall_req = ((state == MM_IDLE) && en && mop) ||
                     ((state == MM_WAIT) && !ack_take && !timeout_hit);

  always_comb begin
    state_nxt = state;
    if (en) begin
      case (state)
        MM_IDLE: if (mop) state_nxt = MM_WAIT;
        MM_WAIT: if (dmem_ack || timeout_hit) state_nxt = MM_IDLE;
        default: state_nxt = MM_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= MM_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dmem_req        <= 1'b0;
      dmem_we         <= 1'b0;
      dmem_addr       <= '0;
      dmem_wdata      <= '0;
      out_flush       <= 1'b1;
      out_reg_wr      <= 1'b0;
      out_reg_addr_rd <= '0;
      out_reg_data    <= '0;
    end else if (en) begin
      case (state)
        MM_IDLE: begin
          if (mop) begin
            dmem_req   <= 1'b1;
            dmem_we    <= in_mem_wr;
            dmem_addr  <= in_alu_res;
            dmem_wdata <= in_mem_wdata;
            out_flush  <= 1'b1;
          end else begin
            out_reg_data    <= in_alu_res;
            out_reg_wr      <= in_reg_wr && !in_flush;
            out_reg_addr_rd <= in_reg_addr_rd;
            out_flush       <= in_flush;
          end
        end
        MM_WAIT: begin
          if (dmem_ack) begin
            dmem_req        <= 1'b0;
            out_reg_data    <= in_mem_rd ? dmem_rdata : in_alu_res;
            out_reg_wr      <= in_reg_wr && !in_mem_wr;
            out_reg_addr_rd <= in_reg_addr_rd;
            out_flush       <= 1'b0;
          end else begin
            if (timeout_hit) dmem_req <= 1'b0;
            out_flush <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ffw_MM_reg_wr      = out_reg_wr && !out_flush;
  assign ffw_MM_reg_addr_rd = out_reg_addr_rd;
  assign ffw_MM_reg_data_rd = out_reg_data;
  assign state_dbg          = state;

endmodule
